// File: rtl/mips_stage_seq.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the single-clock MIPS datapath.
// Issues one-cycle Moore enables per stage and keeps cycle/retire counters.
module mips_stage_seq #(
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             run,
   input  logic             halt_req,
   input  logic [31:0]      Ins,
   output logic             ir_we,
   output logic             rf_re,
   output logic             ex_en,
   output logic             hilo_we,
   output logic             mem_en,
   output logic             mem_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic [2:0]       stage,
   output logic             halted,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_IF     = 3'd1,
      S_ID     = 3'd2,
      S_EX     = 3'd3,
      S_EXWAIT = 3'd4,
      S_MEM    = 3'd5,
      S_WB     = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_MULDIV, C_SYSCALL, C_LOAD, C_STORE, C_BRJ, C_JAL
   } cls_t;

   localparam logic [3:0] WAIT_INIT = 4'(MULDIV_LAT - 1);

   state_t           state_q, state_d;
   cls_t             cls_q, cls_d, cls_dec;
   logic [3:0]       wait_q, wait_d;
   logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;
   state_t           boundary_state;
   logic             busy;

   logic [5:0] opcode, funct;
   logic       unused_ins_bits;
   assign opcode          = Ins[31:26];
   assign funct           = Ins[5:0];
   assign unused_ins_bits = ^Ins[25:6];

   always_comb begin
      cls_dec = C_ALU;
      case (opcode)
         6'b000000: begin
            if (funct[5:2] == 4'b0110)   cls_dec = C_MULDIV;
            else if (funct == 6'b001100) cls_dec = C_SYSCALL;
            else if (funct == 6'b001000) cls_dec = C_BRJ;
         end
         6'b100011:                      cls_dec = C_LOAD;
         6'b101011:                      cls_dec = C_STORE;
         6'b000100, 6'b000101, 6'b000010: cls_dec = C_BRJ;
         6'b000011:                      cls_dec = C_JAL;
         default:                        cls_dec = C_ALU;
      endcase
   end

   // run and halt_req only matter at an instruction boundary (the pc_we cycle)
   assign boundary_state = (halt_req || !run) ? S_HALT : S_IF;

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      wait_d  = wait_q;
      ir_we   = 1'b0;
      rf_re   = 1'b0;
      ex_en   = 1'b0;
      hilo_we = 1'b0;
      mem_en  = 1'b0;
      mem_we  = 1'b0;
      rf_we   = 1'b0;
      pc_we   = 1'b0;
      halted  = 1'b0;
      case (state_q)
         S_IDLE: if (run) state_d = S_IF;
         S_IF: begin
            ir_we   = 1'b1;
            state_d = S_ID;
         end
         S_ID: begin
            rf_re   = 1'b1;
            cls_d   = cls_dec;
            state_d = S_EX;
         end
         S_EX: begin
            ex_en = 1'b1;
            case (cls_q)
               C_MULDIV: begin
                  state_d = S_EXWAIT;
                  wait_d  = WAIT_INIT;
               end
               C_LOAD, C_STORE: state_d = S_MEM;
               C_BRJ: begin
                  pc_we   = 1'b1;
                  state_d = boundary_state;
               end
               C_SYSCALL: begin
                  pc_we   = 1'b1;
                  state_d = S_HALT;
               end
               default: state_d = S_WB;
            endcase
         end
         S_EXWAIT: begin
            ex_en = 1'b1;
            if (wait_q == 4'd0) begin
               hilo_we = 1'b1;
               pc_we   = 1'b1;
               state_d = boundary_state;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         S_MEM: begin
            mem_en = 1'b1;
            if (cls_q == C_STORE) begin
               mem_we  = 1'b1;
               pc_we   = 1'b1;
               state_d = boundary_state;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = boundary_state;
         end
         S_HALT: begin
            halted = 1'b1;
            if (!run && !halt_req) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy  = (state_q != S_IDLE) && (state_q != S_HALT);
   assign cyc_d = cyc_q + {{(CNT_W-1){1'b0}}, busy};
   assign ret_d = ret_q + {{(CNT_W-1){1'b0}}, pc_we};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cls_q   <= C_ALU;
         wait_q  <= 4'd0;
         cyc_q   <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         wait_q  <= wait_d;
         cyc_q   <= cyc_d;
         ret_q   <= ret_d;
      end
   end

   assign stage   = state_q;
   assign cyc_cnt = cyc_q;
   assign ret_cnt = ret_q;

endmodule

// File: tb/tb_mips_stage_seq.sv
// Directed bench for mips_stage_seq: per-cycle stage/enable checks per class,
// halt/run handshake, counters, and async reset in the middle of a DIV.
module tb_mips_stage_seq;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        run = 1'b0;
   logic        halt_req = 1'b0;
   logic [31:0] Ins = 32'h0;
   logic        ir_we, rf_re, ex_en, hilo_we, mem_en, mem_we, rf_we, pc_we;
   logic [2:0]  stage;
   logic        halted;
   logic [31:0] cyc_cnt, ret_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [31:0] I_ADD  = 32'h00221820;
   localparam logic [31:0] I_MULT = 32'h00430018;
   localparam logic [31:0] I_LW   = 32'h8C220004;
   localparam logic [31:0] I_SW   = 32'hAC220004;
   localparam logic [31:0] I_BEQ  = 32'h10220003;
   localparam logic [31:0] I_JR   = 32'h03E00008;
   localparam logic [31:0] I_SYS  = 32'h0000000C;
   localparam logic [31:0] I_DIV  = 32'h0043001A;

   // enable vector order: ir_we rf_re ex_en hilo_we mem_en mem_we rf_we pc_we
   localparam logic [7:0] E_NONE = 8'b0000_0000;
   localparam logic [7:0] E_IF   = 8'b1000_0000;
   localparam logic [7:0] E_ID   = 8'b0100_0000;
   localparam logic [7:0] E_EX   = 8'b0010_0000;
   localparam logic [7:0] E_EXPC = 8'b0010_0001;
   localparam logic [7:0] E_HILO = 8'b0011_0001;
   localparam logic [7:0] E_LD   = 8'b0000_1000;
   localparam logic [7:0] E_ST   = 8'b0000_1101;
   localparam logic [7:0] E_WB   = 8'b0000_0011;

   mips_stage_seq #(.MULDIV_LAT(4), .CNT_W(32)) dut (
      .CLK(CLK), .RST(RST), .run(run), .halt_req(halt_req), .Ins(Ins),
      .ir_we(ir_we), .rf_re(rf_re), .ex_en(ex_en), .hilo_we(hilo_we),
      .mem_en(mem_en), .mem_we(mem_we), .rf_we(rf_we), .pc_we(pc_we),
      .stage(stage), .halted(halted), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // check the current cycle's stage, enables and halted, then advance one clock
   task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] en);
      chk({tag, ".stage"}, {29'd0, stage}, {29'd0, st});
      chk({tag, ".en"}, {24'd0, ir_we, rf_re, ex_en, hilo_we, mem_en, mem_we, rf_we, pc_we},
          {24'd0, en});
      chk({tag, ".halted"}, {31'd0, halted}, {31'd0, (st == 3'd7)});
      $display("cycle %-10s stage=%0d en=%b cyc=%0d ret=%0d", tag, stage,
               {ir_we, rf_re, ex_en, hilo_we, mem_en, mem_we, rf_we, pc_we}, cyc_cnt, ret_cnt);
      step();
   endtask

   task automatic cnts(input string tag, input int c, input int r);
      chk({tag, ".cyc_cnt"}, cyc_cnt, c);
      chk({tag, ".ret_cnt"}, ret_cnt, r);
   endtask

   initial begin
      step();
      step();
      RST = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc("reset_idle", 3'd0, E_NONE);
         cnts("reset_idle", 0, 0);
      end

      // ADD x3: 4 cycles each
      run = 1'b1;
      Ins = I_ADD;
      step();
      for (int g = 0; g < 3; g++) begin
         cyc("add_if", 3'd1, E_IF);
         cyc("add_id", 3'd2, E_ID);
         cyc("add_ex", 3'd3, E_EX);
         cyc("add_wb", 3'd6, E_WB);
      end
      cnts("add_x3", 12, 3);

      // MULT, MULDIV_LAT=4 -> 7 cycles, ex_en for 5
      Ins = I_MULT;
      cyc("mult_if", 3'd1, E_IF);
      cyc("mult_id", 3'd2, E_ID);
      cyc("mult_ex", 3'd3, E_EX);
      cyc("mult_w3", 3'd4, E_EX);
      cyc("mult_w2", 3'd4, E_EX);
      cyc("mult_w1", 3'd4, E_EX);
      cyc("mult_w0", 3'd4, E_HILO);
      cnts("mult", 19, 4);

      Ins = I_LW;
      cyc("lw_if", 3'd1, E_IF);
      cyc("lw_id", 3'd2, E_ID);
      cyc("lw_ex", 3'd3, E_EX);
      cyc("lw_mem", 3'd5, E_LD);
      cyc("lw_wb", 3'd6, E_WB);
      cnts("lw", 24, 5);

      Ins = I_SW;
      cyc("sw_if", 3'd1, E_IF);
      cyc("sw_id", 3'd2, E_ID);
      cyc("sw_ex", 3'd3, E_EX);
      cyc("sw_mem", 3'd5, E_ST);
      cnts("sw", 28, 6);

      Ins = I_BEQ;
      cyc("beq_if", 3'd1, E_IF);
      cyc("beq_id", 3'd2, E_ID);
      cyc("beq_ex", 3'd3, E_EXPC);
      cnts("beq", 31, 7);

      Ins = I_JR;
      cyc("jr_if", 3'd1, E_IF);
      cyc("jr_id", 3'd2, E_ID);
      cyc("jr_ex", 3'd3, E_EXPC);
      cnts("jr", 34, 8);

      // SYSCALL halts even with run held high
      Ins = I_SYS;
      cyc("sys_if", 3'd1, E_IF);
      cyc("sys_id", 3'd2, E_ID);
      cyc("sys_ex", 3'd3, E_EXPC);
      cyc("sys_halt", 3'd7, E_NONE);
      cnts("sys_halt", 37, 9);
      run = 1'b0;
      cyc("sys_halt2", 3'd7, E_NONE);
      cyc("sys_idle", 3'd0, E_NONE);
      cnts("sys_idle", 37, 9);

      // halt_req raised during ID: ADD still completes, then HALT
      run = 1'b1;
      Ins = I_ADD;
      step();
      cyc("hreq_if", 3'd1, E_IF);
      halt_req = 1'b1;
      cyc("hreq_id", 3'd2, E_ID);
      cyc("hreq_ex", 3'd3, E_EX);
      cyc("hreq_wb", 3'd6, E_WB);
      cyc("hreq_halt", 3'd7, E_NONE);
      cnts("hreq", 41, 10);
      halt_req = 1'b0;
      run = 1'b0;
      cyc("hreq_halt2", 3'd7, E_NONE);
      cyc("hreq_idle", 3'd0, E_NONE);

      // run dropped mid-instruction is honoured only at the boundary
      run = 1'b1;
      step();
      cyc("rdrop_if", 3'd1, E_IF);
      run = 1'b0;
      cyc("rdrop_id", 3'd2, E_ID);
      cyc("rdrop_ex", 3'd3, E_EX);
      cyc("rdrop_wb", 3'd6, E_WB);
      cyc("rdrop_halt", 3'd7, E_NONE);
      cyc("rdrop_idle", 3'd0, E_NONE);
      cnts("rdrop", 45, 11);

      // async reset during EXWAIT of a DIV
      run = 1'b1;
      Ins = I_DIV;
      step();
      cyc("div_if", 3'd1, E_IF);
      cyc("div_id", 3'd2, E_ID);
      cyc("div_ex", 3'd3, E_EX);
      chk("div_exwait.stage", {29'd0, stage}, 32'd4);
      #2;
      RST = 1'b1;
      #1;
      chk("div_rst.stage", {29'd0, stage}, 32'd0);
      chk("div_rst.en", {24'd0, ir_we, rf_re, ex_en, hilo_we, mem_en, mem_we, rf_we, pc_we}, 32'd0);
      cnts("div_rst", 0, 0);
      run = 1'b0;
      step();
      cyc("div_rst_hold", 3'd0, E_NONE);
      RST = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc("post_rst", 3'd0, E_NONE);
      end
      cnts("post_rst", 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_stage_seq.md
Name: mips_stage_seq

Overview:
- Multi-cycle stage sequencer for the single-clock MIPS IF/ID/EX datapath.
- Walks each instruction through IF, ID, EX, MEM and WB and issues one-cycle enables to each unit.
- Holds the PC until the instruction retires.
- Inserts a fixed wait for MULT/DIV so HI/LO complete before the next fetch; supports run/halt and performance counters.

Parameters:
- MULDIV_LAT, 4, extra EX cycles for MULT/MULTU/DIV/DIVU (1..15)
- CNT_W, 32, width of cycle and retired-instruction counters

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous active-high reset
- run  in  1  level; start/continue sequencing
- halt_req  in  1  request stop at next instruction boundary
- Ins  in  32  current instruction from IF unit (stable while PC held)
- ir_we  out  1  latch fetched instruction (IF state)
- rf_re  out  1  register-file read / Ed32 sign-extend valid (ID state)
- ex_en  out  1  ALU/branch evaluation enable (EX and EXWAIT)
- hilo_we  out  1  HI/LO write, last EXWAIT cycle only
- mem_en  out  1  data-memory access (MEM state)
- mem_we  out  1  data-memory write, SW only, with mem_en
- rf_we  out  1  register write-back (WB state)
- pc_we  out  1  load newPC; exactly one cycle per retired instruction
- stage  out  3  encoded state: IDLE=0, IF=1, ID=2, EX=3, EXWAIT=4, MEM=5, WB=6, HALT=7
- halted  out  1  high in HALT
- cyc_cnt  out  CNT_W  cycles spent outside IDLE/HALT
- ret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async, any state, mid-instruction included): state IDLE; wait counter 0; cyc_cnt=0; ret_cnt=0; all enables 0; stage=0; halted=0.
- All enables are Moore outputs, decoded from registered state; no combinational path from Ins to any enable.
- Ins is decoded in ID; the instruction class is registered at the ID->EX transition.
- Classes, by opcode[31:26] / funct[5:0]:
  - MULDIV: opcode 000000, funct 011000..011011.
  - SYSCALL: opcode 000000, funct 001100.
  - LOAD: opcode 100011.
  - STORE: opcode 101011.
  - BRJ: opcode 000100, 000101, 000010, and R-type JR (funct 001000).
  - JAL: opcode 000011.
  - ALU: all other encodings, including unknown opcodes.
- Transitions:
  - IDLE: run=1 -> IF; else stay.
  - IF -> ID (ir_we=1).
  - ID -> EX (rf_re=1).
  - EX (ex_en=1):
    - MULDIV -> EXWAIT, with wait counter loaded to MULDIV_LAT-1.
    - LOAD/STORE -> MEM.
    - ALU/JAL -> WB.
    - BRJ -> boundary, pc_we=1 in EX.
    - SYSCALL -> HALT, pc_we=1 in EX.
  - EXWAIT (ex_en=1): counter decrements each cycle. At 0: hilo_we=1, pc_we=1 -> boundary. MULDIV latency is exactly 3+MULDIV_LAT cycles (IF, ID, EX, plus MULDIV_LAT EXWAIT cycles).
  - MEM (mem_en=1; mem_we=1 if STORE):
    - LOAD -> WB.
    - STORE -> boundary, pc_we=1 in MEM.
  - WB (rf_we=1, pc_we=1) -> boundary.
  - Boundary: halt_req=1 or run=0 -> HALT; else IF.
  - HALT: halted=1. run=0 and halt_req=0 -> IDLE; otherwise stay.
- halt_req is sampled only in the cycle pc_we=1 and never aborts an in-flight instruction.
- run deassertion mid-instruction is ignored until the boundary.
- Cycle counts per class: ALU/JAL 4, LOAD 5, STORE 4, BRJ 3, SYSCALL 3, MULDIV 3+MULDIV_LAT.
- cyc_cnt increments every cycle whose state is not IDLE or HALT.
- ret_cnt increments on every pc_we cycle. Both counters wrap modulo 2^CNT_W, with no saturation.
- Invariant: exactly one of {ir_we, rf_re, ex_en, mem_en, rf_we} is high in IF..WB; none are high in IDLE/HALT.
- hilo_we and rf_we are never high in the same cycle.

Test Plan:
- RST=1 then release, run=0 for 5 cycles -> stage=0, all enables 0, cyc_cnt=0.
- run=1, Ins=0x00221820 (ADD $3,$1,$2) held -> stage 1,2,3,6 repeating. rf_we and pc_we high in cycle 4 of each group. After 12 cycles: ret_cnt=3, cyc_cnt=12.
- Ins=0x00430018 (MULT $2,$3), MULDIV_LAT=4 -> ex_en high 5 consecutive cycles; hilo_we and pc_we together on the 7th cycle only; rf_we never high.
- Ins=0x8C220004 (LW) -> mem_en in cycle 4 with mem_we=0, rf_we in cycle 5. Ins=0xAC220004 (SW) -> mem_en=mem_we=1 and pc_we in cycle 4; no rf_we.
- Ins=0x0000000C (SYSCALL) -> pc_we in cycle 3, then stage=7, halted=1. Drop run -> IDLE next cycle. halt_req=1 raised in ID of an ADD -> ADD completes WB, then HALT.
- Assert RST during EXWAIT of a DIV (Ins=0x0043001A) -> same-cycle async return to IDLE; counters 0; no hilo_we or pc_we pulse.
